// File: rtl/regread_alu.sv
// Register-read stage between the issue queue and executeALU: reads sources from the RF,
// overrides them with bypass data, holds the uop across execute stalls, and tracks branch kill/resolve.
module regread_alu #(
  parameter int WIDTH_BRM = 4,
  parameter int WIDTH_REG = 7,
  localparam int WIDTH = 1 + 7 + WIDTH_BRM + WIDTH_REG + 10 + 4 * 32
) (
  input  logic                   i_clk,
  input  logic                   i_rst,
  input  logic                   i_valid,
  output logic                   o_ready,
  input  logic [6:0]             i_uop,
  input  logic [WIDTH_BRM-1:0]   i_brmask,
  input  logic [WIDTH_REG-1:0]   i_rd,
  input  logic [WIDTH_REG-1:0]   i_rs1,
  input  logic [WIDTH_REG-1:0]   i_rs2,
  input  logic [31:0]            i_pc,
  input  logic [31:0]            i_imm,
  input  logic [9:0]             i_func,
  output logic [WIDTH_REG-1:0]   o_rs1_addr,
  output logic [WIDTH_REG-1:0]   o_rs2_addr,
  input  logic [31:0]            i_rs1_data,
  input  logic [31:0]            i_rs2_data,
  input  logic [32+WIDTH_REG:0]  i_bypass0,
  input  logic [32+WIDTH_REG:0]  i_bypass1,
  input  logic                   i_br_kill,
  input  logic [WIDTH_BRM-1:0]   i_br_kill_mask,
  input  logic                   i_br_done,
  input  logic [WIDTH_BRM-1:0]   i_br_done_mask,
  input  logic                   i_ex_ready,
  output logic [WIDTH-1:0]       o_instr
);

  // Handshake: a uop moves in on i_valid & o_ready; the packet leaves whenever i_ex_ready is high.
  logic                 s_val;
  logic [6:0]           s_uop;
  logic [WIDTH_BRM-1:0] s_brmask;
  logic [WIDTH_REG-1:0] s_rd, s_rs1, s_rs2;
  logic [31:0]          s_pc, s_imm;
  logic [9:0]           s_func;
  logic                 s_cap1, s_cap2;
  logic [31:0]          s_cap1_d, s_cap2_d;

  logic                 kill_hit, accept, accept_kill;
  logic [WIDTH_BRM-1:0] done_clr, brmask_out;
  logic [32:0]          byp1, byp2;
  logic [31:0]          op1, op2;

  // Returns {hit, data}; bypass0 wins, and p0 is never forwarded.
  function automatic logic [32:0] bypass_pick(input logic [WIDTH_REG-1:0] rs,
                                              input logic [32+WIDTH_REG:0] b0,
                                              input logic [32+WIDTH_REG:0] b1);
    logic [32:0] r;
    r = '0;
    if (rs != '0) begin
      if (b0[32+WIDTH_REG] && (b0[31+WIDTH_REG:32] == rs))      r = {1'b1, b0[31:0]};
      else if (b1[32+WIDTH_REG] && (b1[31+WIDTH_REG:32] == rs)) r = {1'b1, b1[31:0]};
    end
    return r;
  endfunction

  always_comb begin
    done_clr    = i_br_done ? i_br_done_mask : '0;
    brmask_out  = s_brmask & ~done_clr;
    kill_hit    = s_val & i_br_kill & (|(s_brmask & i_br_kill_mask));
    accept_kill = i_br_kill & (|(i_brmask & i_br_kill_mask));
    o_ready     = ~s_val | i_ex_ready | kill_hit;
    accept      = i_valid & o_ready;
    byp1        = bypass_pick(s_rs1, i_bypass0, i_bypass1);
    byp2        = bypass_pick(s_rs2, i_bypass0, i_bypass1);
    op1         = s_cap1 ? s_cap1_d : byp1[32] ? byp1[31:0] : (s_rs1 == '0) ? 32'h0 : i_rs1_data;
    op2         = s_cap2 ? s_cap2_d : byp2[32] ? byp2[31:0] : (s_rs2 == '0) ? 32'h0 : i_rs2_data;
  end

  assign o_rs1_addr = s_rs1;
  assign o_rs2_addr = s_rs2;
  assign o_instr    = {s_val & ~kill_hit, s_uop, brmask_out, s_rd, s_pc, s_func, s_imm, op2, op1};

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s_val    <= 1'b0;
      s_uop    <= '0;
      s_brmask <= '0;
      s_rd     <= '0;
      s_rs1    <= '0;
      s_rs2    <= '0;
      s_pc     <= '0;
      s_func   <= '0;
      s_imm    <= '0;
      s_cap1   <= 1'b0;
      s_cap2   <= 1'b0;
      s_cap1_d <= '0;
      s_cap2_d <= '0;
    end else if (accept) begin
      s_val    <= ~accept_kill;
      s_uop    <= i_uop;
      s_brmask <= i_brmask & ~done_clr;
      s_rd     <= i_rd;
      s_rs1    <= i_rs1;
      s_rs2    <= i_rs2;
      s_pc     <= i_pc;
      s_func   <= i_func;
      s_imm    <= i_imm;
      s_cap1   <= 1'b0;
      s_cap2   <= 1'b0;
    end else begin
      if (kill_hit || (s_val && i_ex_ready)) s_val <= 1'b0;
      s_brmask <= brmask_out;
      // A bypass only pulses once, so a stalled uop must latch it or lose the value.
      if (s_val && !i_ex_ready && !s_cap1 && byp1[32]) begin
        s_cap1   <= 1'b1;
        s_cap1_d <= byp1[31:0];
      end
      if (s_val && !i_ex_ready && !s_cap2 && byp2[32]) begin
        s_cap2   <= 1'b1;
        s_cap2_d <= byp2[31:0];
      end
    end
  end

endmodule

// File: tb/tb_regread_alu.sv
// Bench for regread_alu: directed scenarios followed by random traffic, each cycle checked
// against a behavioural model of the held uop.
module tb_regread_alu;
  localparam int WB = 4;
  localparam int WR = 7;
  localparam int W  = 1 + 7 + WB + WR + 10 + 4 * 32;

  logic          i_clk = 1'b0;
  logic          i_rst, i_valid, o_ready;
  logic [6:0]    i_uop;
  logic [WB-1:0] i_brmask, i_br_kill_mask, i_br_done_mask;
  logic [WR-1:0] i_rd, i_rs1, i_rs2, o_rs1_addr, o_rs2_addr;
  logic [31:0]   i_pc, i_imm, i_rs1_data, i_rs2_data;
  logic [9:0]    i_func;
  logic [32+WR:0] i_bypass0, i_bypass1;
  logic          i_br_kill, i_br_done, i_ex_ready;
  logic [W-1:0]  o_instr;

  logic [31:0] rf [2**WR];
  always_comb i_rs1_data = rf[o_rs1_addr];
  always_comb i_rs2_data = rf[o_rs2_addr];

  regread_alu #(.WIDTH_BRM(WB), .WIDTH_REG(WR)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .o_ready(o_ready),
    .i_uop(i_uop), .i_brmask(i_brmask), .i_rd(i_rd), .i_rs1(i_rs1), .i_rs2(i_rs2),
    .i_pc(i_pc), .i_imm(i_imm), .i_func(i_func),
    .o_rs1_addr(o_rs1_addr), .o_rs2_addr(o_rs2_addr),
    .i_rs1_data(i_rs1_data), .i_rs2_data(i_rs2_data),
    .i_bypass0(i_bypass0), .i_bypass1(i_bypass1),
    .i_br_kill(i_br_kill), .i_br_kill_mask(i_br_kill_mask),
    .i_br_done(i_br_done), .i_br_done_mask(i_br_done_mask),
    .i_ex_ready(i_ex_ready), .o_instr(o_instr)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic          val;
    logic [6:0]    uop;
    logic [WB-1:0] brm;
    logic [WR-1:0] rd, rs1, rs2;
    logic [31:0]   pc, imm;
    logic [9:0]    func;
    logic          cap1, cap2;
    logic [31:0]   cap1_d, cap2_d;
  } held_t;

  held_t        m;
  int           n_tests = 0;
  int           n_fail  = 0;
  logic [W-1:0] last_instr;
  logic         last_ready;
  logic [W-1:0] exp_q [$];

  task automatic check(input string tag, input logic [W-1:0] obs, input logic [W-1:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic bus_hit(input logic [32+WR:0] b, input logic [WR-1:0] rs);
    return b[32+WR] && (b[31+WR:32] == rs) && (rs != '0);
  endfunction

  function automatic logic [31:0] exp_op(input logic [WR-1:0] rs, input logic cap, input logic [31:0] capd);
    if (cap) return capd;
    if (bus_hit(i_bypass0, rs)) return i_bypass0[31:0];
    if (bus_hit(i_bypass1, rs)) return i_bypass1[31:0];
    if (rs == '0) return 32'h0;
    return rf[rs];
  endfunction

  function automatic logic kill_now();
    return m.val && i_br_kill && ((m.brm & i_br_kill_mask) != '0);
  endfunction

  function automatic logic [W-1:0] exp_pkt();
    logic [WB-1:0] dclr;
    dclr = i_br_done ? i_br_done_mask : '0;
    return {m.val && !kill_now(), m.uop, m.brm & ~dclr, m.rd, m.pc, m.func, m.imm,
            exp_op(m.rs2, m.cap2, m.cap2_d), exp_op(m.rs1, m.cap1, m.cap1_d)};
  endfunction

  task automatic model_edge();
    logic          khit, acc;
    logic [WB-1:0] dclr;
    if (i_rst) begin
      m = '{default: '0};
      return;
    end
    dclr = i_br_done ? i_br_done_mask : '0;
    khit = kill_now();
    acc  = i_valid && (!m.val || i_ex_ready || khit);
    if (acc) begin
      m.val  = !(i_br_kill && ((i_brmask & i_br_kill_mask) != '0));
      m.uop  = i_uop;  m.brm = i_brmask & ~dclr;  m.rd = i_rd;
      m.rs1  = i_rs1;  m.rs2 = i_rs2;  m.pc = i_pc;  m.imm = i_imm;  m.func = i_func;
      m.cap1 = 1'b0;   m.cap2 = 1'b0;
    end else begin
      if (m.val && !i_ex_ready) begin
        if (!m.cap1 && (bus_hit(i_bypass0, m.rs1) || bus_hit(i_bypass1, m.rs1))) begin
          m.cap1_d = exp_op(m.rs1, 1'b0, 32'h0);
          m.cap1   = 1'b1;
        end
        if (!m.cap2 && (bus_hit(i_bypass0, m.rs2) || bus_hit(i_bypass1, m.rs2))) begin
          m.cap2_d = exp_op(m.rs2, 1'b0, 32'h0);
          m.cap2   = 1'b1;
        end
      end
      if (khit || (m.val && i_ex_ready)) m.val = 1'b0;
      m.brm = m.brm & ~dclr;
    end
  endtask

  // One cycle: compare outputs mid-cycle, then advance the model on the edge.
  task automatic step();
    @(negedge i_clk);
    last_instr = o_instr;
    last_ready = o_ready;
    check("packet", o_instr, exp_pkt());
    check("ready", W'(o_ready), W'(!m.val || i_ex_ready || kill_now()));
    check("rf_addr", W'({o_rs1_addr, o_rs2_addr}), W'({m.rs1, m.rs2}));
    @(posedge i_clk);
    model_edge();
    #1;
  endtask

  task automatic idle();
    i_valid = 1'b0;  i_bypass0 = '0;  i_bypass1 = '0;
    i_br_kill = 1'b0;  i_br_kill_mask = '0;  i_br_done = 1'b0;  i_br_done_mask = '0;
    i_ex_ready = 1'b1;
  endtask

  task automatic issue(input logic [6:0] uop, input logic [WB-1:0] brm,
                       input logic [WR-1:0] rs1, input logic [WR-1:0] rs2);
    i_valid = 1'b1;  i_uop = uop;  i_brmask = brm;  i_rs1 = rs1;  i_rs2 = rs2;
    i_rd = WR'($urandom);  i_pc = $urandom;  i_imm = $urandom;  i_func = 10'($urandom);
  endtask

  initial begin
    m = '{default: '0};
    for (int i = 0; i < 2**WR; i++) rf[i] = $urandom;
    idle();
    issue(7'h3, 4'h0, 7'd5, 7'd9);
    i_rst = 1'b1;
    @(posedge i_clk);
    model_edge();
    #1;
    step();
    step();
    check("rst_instr", last_instr, '0);
    check("rst_ready", W'(last_ready), W'(1'b1));
    i_rst = 1'b0;
    idle();
    step();
    check("rst_nothing_accepted", W'(last_instr[W-1]), W'(1'b0));

    // RF read
    rf[5] = 32'h11;  rf[9] = 32'h22;
    issue(7'h21, 4'h0, 7'd5, 7'd9);
    step();
    idle();
    step();
    check("rf_op1", W'(last_instr[31:0]), W'(32'h11));
    check("rf_op2", W'(last_instr[63:32]), W'(32'h22));
    check("rf_val", W'(last_instr[W-1]), W'(1'b1));

    // Bypass priority, and p0 never forwarded
    issue(7'h22, 4'h0, 7'd5, 7'd0);
    step();
    idle();
    i_bypass0 = {1'b1, 7'd5, 32'hAA};
    i_bypass1 = {1'b1, 7'd5, 32'hBB};
    step();
    check("byp_prio_op1", W'(last_instr[31:0]), W'(32'hAA));
    issue(7'h23, 4'h0, 7'd0, 7'd0);
    i_bypass0 = '0;  i_bypass1 = '0;
    step();
    idle();
    i_bypass0 = {1'b1, 7'd0, 32'hCC};
    step();
    check("byp_p0_op1", W'(last_instr[31:0]), W'(32'h0));

    // Stall capture
    rf[9] = 32'h0;
    idle();
    issue(7'h24, 4'h0, 7'd5, 7'd9);
    step();
    idle();
    i_ex_ready = 1'b0;
    step();
    check("stall1_ready", W'(last_ready), W'(1'b0));
    i_bypass1 = {1'b1, 7'd9, 32'h77};
    step();
    check("stall2_op2", W'(last_instr[63:32]), W'(32'h77));
    i_bypass1 = '0;
    step();
    check("stall3_op2", W'(last_instr[63:32]), W'(32'h77));
    check("stall3_ready", W'(last_ready), W'(1'b0));
    i_ex_ready = 1'b1;
    step();
    check("release_op2", W'(last_instr[63:32]), W'(32'h77));
    check("release_val", W'(last_instr[W-1]), W'(1'b1));

    // Kill on held uop
    issue(7'h25, 4'b0010, 7'd1, 7'd2);
    step();
    idle();
    i_ex_ready = 1'b0;
    step();
    i_br_kill = 1'b1;  i_br_kill_mask = 4'b0010;
    step();
    check("kill_val", W'(last_instr[W-1]), W'(1'b0));
    check("kill_ready", W'(last_ready), W'(1'b1));
    i_br_kill = 1'b0;
    step();
    check("kill_after_val", W'(last_instr[W-1]), W'(1'b0));
    issue(7'h26, 4'b0010, 7'd1, 7'd2);
    i_ex_ready = 1'b1;
    step();
    idle();
    i_ex_ready = 1'b0;
    i_br_kill = 1'b1;  i_br_kill_mask = 4'b0100;
    step();
    check("nokill_val", W'(last_instr[W-1]), W'(1'b1));
    i_br_kill = 1'b0;
    step();
    check("nokill_after_val", W'(last_instr[W-1]), W'(1'b1));
    i_ex_ready = 1'b1;
    step();

    // Branch done
    issue(7'h27, 4'b0011, 7'd3, 7'd4);
    step();
    idle();
    i_ex_ready = 1'b0;
    i_br_done = 1'b1;  i_br_done_mask = 4'b0001;
    step();
    check("done_brmask", W'(last_instr[148:145]), W'(4'b0010));
    i_br_done = 1'b0;
    step();
    check("done_brmask_held", W'(last_instr[148:145]), W'(4'b0010));
    i_ex_ready = 1'b1;
    step();

    // Back-to-back: five uops, five consecutive packets
    for (int j = 0; j < 6; j++) begin
      idle();
      if (j < 5) begin
        issue(7'(7'h10 + j), 4'h0, 7'(j + 1), 7'(j + 2));
        exp_q.push_back(W'({1'b1, 7'(7'h10 + j)}));
      end
      step();
      if (j > 0) check("b2b_order", W'(last_instr[W-1:W-8]), exp_q.pop_front());
    end

    // Random traffic
    for (int c = 0; c < 600; c++) begin
      idle();
      i_rst = ($urandom_range(0, 63) == 0);
      if ($urandom_range(0, 3) != 0)
        issue(7'($urandom), 4'($urandom), 7'($urandom_range(0, 12)), 7'($urandom_range(0, 12)));
      i_ex_ready = ($urandom_range(0, 9) < 6);
      if ($urandom_range(0, 1) == 1) i_bypass0 = {1'b1, 7'($urandom_range(0, 12)), 32'($urandom)};
      if ($urandom_range(0, 1) == 1) i_bypass1 = {1'b1, 7'($urandom_range(0, 12)), 32'($urandom)};
      if ($urandom_range(0, 5) == 0) begin
        i_br_kill = 1'b1;  i_br_kill_mask = 4'(1 << $urandom_range(0, 3));
      end
      if ($urandom_range(0, 3) == 0) begin
        i_br_done = 1'b1;  i_br_done_mask = 4'(1 << $urandom_range(0, 3));
      end
      step();
    end
    i_rst = 1'b0;

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
